// File: rtl/ctrl_pkg.sv
// Shared constants and types for the ID-stage control sequencer.
// Defines opcodes (id_inst[6:2]), ALUOp encodings, FSM states and the ID/EX control bundle.
package ctrl_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MDU_WAIT   = 2'd1,
        ST_FENCE_WAIT = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jal;
        logic       jalr;
        logic       auipc;
        logic       lui;
        logic       mext;
        logic       mdu_div;
        logic       illegal;
        logic       ecall;
        logic       ebreak;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) decoder: instruction word to ID/EX control bundle.
// Also flags FENCE, which has an all-zero bundle but still needs sequencing.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        fence
);

    logic [4:0] opcode;
    logic       unused_inst;

    assign opcode      = inst[6:2];
    assign unused_inst = ^inst;

    always_comb begin
        ctrl  = '0;
        fence = 1'b0;
        case (opcode)
            OP_R: begin
                if (inst[31:25] == F7_MEXT && !ENABLE_M) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.alu_op    = ALU_R;
                    ctrl.reg_write = 1'b1;
                    if (inst[31:25] == F7_MEXT) begin
                        ctrl.mext    = 1'b1;
                        ctrl.mdu_div = inst[14];
                    end
                end
            end
            OP_IMM: begin
                ctrl.alu_op    = ALU_I;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LOAD: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BR;
            end
            OP_JAL: begin
                ctrl.jal       = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctrl.jalr      = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.auipc     = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.lui       = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_FENCE: fence = 1'b1;
            OP_SYSTEM: begin
                // Bit 20 is the low bit of funct12: 0 = ECALL, 1 = EBREAK.
                ctrl.ecall  = ~inst[20];
                ctrl.ebreak = inst[20];
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ID-stage control unit: registers the decoded bundle into ID/EX and sequences
// MUL/DIV occupancy, FENCE drain and ECALL/EBREAK halt; owns id_ready.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LAT     = 2,
    parameter int DIV_LAT     = 32,
    parameter int FENCE_DRAIN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        stall,
    input  logic        flush,
    input  logic        resume,
    output logic        id_ready,
    output logic        ex_valid,
    output logic        branch,
    output logic        memRead,
    output logic        memToReg,
    output logic        memWrite,
    output logic        ALUSrc,
    output logic        regWrite,
    output logic        jal,
    output logic        jalr,
    output logic        auipc,
    output logic        lui,
    output logic        mext,
    output logic        illegal,
    output logic [1:0]  ALUOp,
    output logic        mdu_div,
    output logic        halted,
    output logic        ecall,
    output logic        ebreak,
    output state_t      fsm_state
);

    localparam int CNT_MAX_A = (DIV_LAT > FENCE_DRAIN) ? DIV_LAT : FENCE_DRAIN;
    localparam int CNT_MAX   = (CNT_MAX_A > MUL_LAT) ? CNT_MAX_A : MUL_LAT;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MUL_LOAD   = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD   = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(FENCE_DRAIN);
    localparam bit            MUL_MULTI  = (MUL_LAT > 1);
    localparam bit            DIV_MULTI  = (DIV_LAT > 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          valid_q, valid_d;
    ctrl_t         dec;
    logic          dec_fence;
    logic          accept;
    logic          mdu_multi;

    ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .inst  (id_inst),
        .ctrl  (dec),
        .fence (dec_fence)
    );

    // Handshake: id_ready depends only on state; the ID instruction transfers at a
    // rising edge when id_valid & id_ready and neither stall nor flush is high.
    assign id_ready  = (state_q == ST_RUN);
    assign accept    = id_valid & id_ready & ~stall & ~flush;
    assign mdu_multi = dec.mdu_div ? DIV_MULTI : MUL_MULTI;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = accept;
        ctrl_d  = accept ? dec : '0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (dec.mext && mdu_multi) begin
                        state_d = ST_MDU_WAIT;
                        cnt_d   = dec.mdu_div ? DIV_LOAD : MUL_LOAD;
                    end else if (dec_fence) begin
                        state_d = ST_FENCE_WAIT;
                        cnt_d   = DRAIN_LOAD;
                    end else if (dec.ecall || dec.ebreak) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_MDU_WAIT, ST_FENCE_WAIT: begin
                if (flush) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (!stall) begin
                    // Leave on the edge where the count would reach zero.
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid  = valid_q;
    assign branch    = ctrl_q.branch;
    assign memRead   = ctrl_q.mem_read;
    assign memToReg  = ctrl_q.mem_to_reg;
    assign memWrite  = ctrl_q.mem_write;
    assign ALUSrc    = ctrl_q.alu_src;
    assign regWrite  = ctrl_q.reg_write;
    assign jal       = ctrl_q.jal;
    assign jalr      = ctrl_q.jalr;
    assign auipc     = ctrl_q.auipc;
    assign lui       = ctrl_q.lui;
    assign mext      = ctrl_q.mext;
    assign illegal   = ctrl_q.illegal;
    assign ALUOp     = ctrl_q.alu_op;
    assign mdu_div   = ctrl_q.mdu_div;
    assign ecall     = ctrl_q.ecall;
    assign ebreak    = ctrl_q.ebreak;
    assign halted    = (state_q == ST_HALT);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (with and without RV32M) share one stimulus
// stream; a behavioural occupancy/halt model predicts every output each cycle.
module tb_ctrl_sequencer;
    import ctrl_pkg::*;

    localparam int N = 2;

    // Expected-bundle bit positions
    localparam int B_EXV = 17, B_BR = 16, B_MR = 15, B_M2R = 14, B_MW = 13, B_SRC = 12;
    localparam int B_RW = 11, B_JAL = 10, B_JALR = 9, B_AUIPC = 8, B_LUI = 7, B_MEXT = 6;
    localparam int B_DIV = 5, B_ILL = 4, B_ECALL = 3, B_EBRK = 2;

    localparam logic [31:0] I_ADD    = 32'h003100B3;
    localparam logic [31:0] I_DIV    = 32'h0220C0B3;
    localparam logic [31:0] I_MUL    = 32'h022080B3;
    localparam logic [31:0] I_FENCE  = 32'h0000000F;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_BAD    = 32'h0000007F;

    int en_m    [N] = '{1, 0};
    int mul_lat [N] = '{2, 3};
    int div_lat [N] = '{32, 4};
    int drain   [N] = '{3, 1};

    // clock / reset and DUT wiring
    logic        clk = 1'b0;
    logic        rst_n, id_valid, stall, flush, resume;
    logic [31:0] id_inst;
    logic [N-1:0] id_ready, ex_valid, branch, mem_read, mem_to_reg, mem_write, alu_src;
    logic [N-1:0] reg_write, jal, jalr, auipc, lui, mext, illegal, mdu_div, halted, ecall, ebreak;
    logic [1:0]  alu_op [N];
    state_t      fsm_st [N];

    always #5 clk = ~clk;

    ctrl_sequencer #(.ENABLE_M(1'b1), .MUL_LAT(2), .DIV_LAT(32), .FENCE_DRAIN(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst), .stall(stall),
        .flush(flush), .resume(resume), .id_ready(id_ready[0]), .ex_valid(ex_valid[0]),
        .branch(branch[0]), .memRead(mem_read[0]), .memToReg(mem_to_reg[0]),
        .memWrite(mem_write[0]), .ALUSrc(alu_src[0]), .regWrite(reg_write[0]), .jal(jal[0]),
        .jalr(jalr[0]), .auipc(auipc[0]), .lui(lui[0]), .mext(mext[0]), .illegal(illegal[0]),
        .ALUOp(alu_op[0]), .mdu_div(mdu_div[0]), .halted(halted[0]), .ecall(ecall[0]),
        .ebreak(ebreak[0]), .fsm_state(fsm_st[0])
    );

    ctrl_sequencer #(.ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(4), .FENCE_DRAIN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst), .stall(stall),
        .flush(flush), .resume(resume), .id_ready(id_ready[1]), .ex_valid(ex_valid[1]),
        .branch(branch[1]), .memRead(mem_read[1]), .memToReg(mem_to_reg[1]),
        .memWrite(mem_write[1]), .ALUSrc(alu_src[1]), .regWrite(reg_write[1]), .jal(jal[1]),
        .jalr(jalr[1]), .auipc(auipc[1]), .lui(lui[1]), .mext(mext[1]), .illegal(illegal[1]),
        .ALUOp(alu_op[1]), .mdu_div(mdu_div[1]), .halted(halted[1]), .ecall(ecall[1]),
        .ebreak(ebreak[1]), .fsm_state(fsm_st[1])
    );

    // scoreboard state
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          busy [N] = '{0, 0};
    state_t      kind [N] = '{ST_RUN, ST_RUN};
    bit          hlt  [N] = '{1'b0, 1'b0};
    logic [17:0] exp_v [N] = '{18'h0, 18'h0};

    function automatic logic [17:0] act_vec(int i);
        return {ex_valid[i], branch[i], mem_read[i], mem_to_reg[i], mem_write[i], alu_src[i],
                reg_write[i], jal[i], jalr[i], auipc[i], lui[i], mext[i], mdu_div[i],
                illegal[i], ecall[i], ebreak[i], alu_op[i]};
    endfunction

    function automatic logic [17:0] exp_decode(int i, logic [31:0] inst);
        logic [17:0] v;
        logic [4:0]  op;
        logic        is_m;
        v = '0;
        v[B_EXV] = 1'b1;
        op   = inst[6:2];
        is_m = (inst[31:25] == 7'b0000001);
        case (op)
            5'b01100: begin
                if (is_m && en_m[i] == 0) v[B_ILL] = 1'b1;
                else begin
                    v[1:0] = 2'b10; v[B_RW] = 1'b1;
                    if (is_m) begin v[B_MEXT] = 1'b1; v[B_DIV] = inst[14]; end
                end
            end
            5'b00100: begin v[1:0] = 2'b11; v[B_SRC] = 1'b1; v[B_RW] = 1'b1; end
            5'b00000: begin v[B_MR] = 1'b1; v[B_M2R] = 1'b1; v[B_SRC] = 1'b1; v[B_RW] = 1'b1; end
            5'b01000: begin v[B_MW] = 1'b1; v[B_SRC] = 1'b1; end
            5'b11000: begin v[B_BR] = 1'b1; v[1:0] = 2'b01; end
            5'b11011: begin v[B_JAL] = 1'b1; v[B_RW] = 1'b1; end
            5'b11001: begin v[B_JALR] = 1'b1; v[B_SRC] = 1'b1; v[B_RW] = 1'b1; end
            5'b00101: begin v[B_AUIPC] = 1'b1; v[B_SRC] = 1'b1; v[B_RW] = 1'b1; end
            5'b01101: begin v[B_LUI] = 1'b1; v[B_SRC] = 1'b1; v[B_RW] = 1'b1; end
            5'b00011: ;
            5'b11100: if (inst[20]) v[B_EBRK] = 1'b1; else v[B_ECALL] = 1'b1;
            default:  v[B_ILL] = 1'b1;
        endcase
        return v;
    endfunction

    function automatic state_t exp_state(int i);
        if (hlt[i]) return ST_HALT;
        if (busy[i] > 0) return kind[i];
        return ST_RUN;
    endfunction

    // Occupancy model: busy = cycles ID still refuses; halt flag; bubble unless accepted.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit          acc;
            logic [17:0] d;
            int          lat;
            if (!rst_n) begin
                busy[i] = 0; hlt[i] = 1'b0; exp_v[i] = '0;
            end else begin
                acc = id_valid && !hlt[i] && busy[i] == 0 && !stall && !flush;
                d = exp_decode(i, id_inst);
                exp_v[i] = acc ? d : 18'h0;
                if (hlt[i]) begin
                    if (resume) hlt[i] = 1'b0;
                end else if (busy[i] > 0) begin
                    if (flush) busy[i] = 0;
                    else if (!stall) busy[i] = busy[i] - 1;
                end else if (acc) begin
                    if (d[B_MEXT]) begin
                        lat = d[B_DIV] ? div_lat[i] : mul_lat[i];
                        busy[i] = lat - 1; kind[i] = ST_MDU_WAIT;
                    end else if (id_inst[6:2] == 5'b00011) begin
                        busy[i] = drain[i]; kind[i] = ST_FENCE_WAIT;
                    end else if (d[B_ECALL] || d[B_EBRK]) begin
                        hlt[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare process
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("dut%0d bundle", i), 32'(act_vec(i)), 32'(exp_v[i]));
                check($sformatf("dut%0d id_ready", i), 32'(id_ready[i]), 32'(!hlt[i] && busy[i] == 0));
                check($sformatf("dut%0d halted", i), 32'(halted[i]), 32'(hlt[i]));
                check($sformatf("dut%0d state", i), 32'(fsm_st[i]), 32'(exp_state(i)));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  ops [13];
        logic [31:0] w;
        logic [4:0]  op;
        ops = '{5'b01100, 5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011,
                5'b11001, 5'b00101, 5'b01101, 5'b00011, 5'b11100, 5'b11111};
        op = ops[$urandom_range(0, 12)];
        if ($urandom_range(0, 20) == 0) op = 5'b01010;
        w = $urandom;
        w[6:0] = {op, 2'b11};
        if (op == 5'b01100) begin
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'b0000000;
                1: w[31:25] = 7'b0100000;
                default: w[31:25] = 7'b0000001;
            endcase
        end
        return w;
    endfunction

    task automatic count_not_ready(output int n);
        n = 0;
        while (!id_ready[0] && n < 60) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0; resume = 1'b0; id_inst = '0;
        step(); step();
        chk_en = 1'b1;
        check("reset bundle", 32'(act_vec(0)), 32'h0);
        check("reset id_ready", 32'(id_ready), 32'h3);
        check("reset halted", 32'(halted), 32'h0);

        rst_n = 1'b1; id_valid = 1'b1; id_inst = I_ADD;
        step();
        check("add bundle", 32'(act_vec(0)), 32'h20802);

        id_inst = I_DIV;
        step();
        check("div bundle", 32'(act_vec(0)), 32'h20862);
        check("div without M", 32'(act_vec(1)), 32'h20010);
        id_valid = 1'b0;
        count_not_ready(n);
        check("div ready-low cycles", 32'(n), 32'd31);
        id_valid = 1'b1; id_inst = I_ADD;
        step();
        check("accept after div", 32'(act_vec(0)), 32'h20802);

        id_inst = I_MUL;
        step();
        check("mul bundle", 32'(act_vec(0)), 32'h20842);
        check("mul without M", 32'(act_vec(1)), 32'h20010);
        id_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("mul flush ready", 32'(id_ready[0]), 32'h1);
        check("mul flush state", 32'(fsm_st[0]), 32'(ST_RUN));

        id_valid = 1'b1; id_inst = I_FENCE;
        step();
        check("fence bundle", 32'(act_vec(0)), 32'h20000);
        id_valid = 1'b0;
        count_not_ready(n);
        check("fence drain cycles", 32'(n), 32'd3);

        id_valid = 1'b1; id_inst = I_EBREAK;
        step();
        check("ebreak bundle", 32'(act_vec(0)), 32'h20004);
        check("ebreak halted", 32'(halted), 32'h3);
        id_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("halt ignores flush", 32'(halted), 32'h3);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume halted", 32'(halted), 32'h0);
        check("resume id_ready", 32'(id_ready), 32'h3);

        id_valid = 1'b1; id_inst = I_BAD;
        step();
        check("bad opcode bundle", 32'(act_vec(0)), 32'h20010);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall bubble", 32'(act_vec(0)), 32'h0);
            check("stall state", 32'(fsm_st[0]), 32'(ST_RUN));
        end
        stall = 1'b0; id_valid = 1'b0;
        step();

        // randomized phase
        for (int k = 0; k < 4000; k++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_inst  = rand_inst();
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            resume   = ($urandom_range(0, 3) == 0);
            step();
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
